rst_ce_sequencer: RTL and testbench

- Controller that sequences reset release and clock-enable for a downstream datapath.
- Guarantees the contract "rst_o until ce_o": rst_o stays high until ce_o rises, with at least one overlap cycle and no gap between them.
- Guarantees the strong form "rst_o s_until ce_o" when a start request arrives; a sticky flag is raised if no request arrives before the timeout.
- Sits between the system reset and one datapath; gives software-style start, pause and soft-reset handshakes.

---
 rtl/rst_ce_pkg.sv | 49 ++++
 rtl/rst_ce_sequencer_if.sv | 22 ++
 rtl/cyc_down_counter.sv | 35 +++
 rtl/rst_ce_sequencer.sv | 119 +++++++++++
 tb/tb_rst_ce_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/rst_ce_pkg.sv
// Shared types for the reset/clock-enable sequencer: state encoding, output bundle, counter sizing.
// Pure declarations; no latency or flow control of its own.
package rst_ce_pkg;

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_ARMED   = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_PAUSE   = 3'd4
    } state_e;

    typedef struct packed {
        logic rst;
        logic ce;
        logic ack;
    } out_t;

    localparam out_t OUT_RESET = '{rst: 1'b1, ce: 1'b0, ack: 1'b0};

    function automatic int max3(int a, int b, int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    function automatic int cnt_width(int hold_cyc, int overlap_cyc, int timeout_cyc);
        return $clog2(max3(hold_cyc, overlap_cyc, timeout_cyc) + 1);
    endfunction

    // Moore decode of rst/ce; ack depends on the transition and is filled in by the caller.
    function automatic out_t decode(state_e s);
        out_t o;
        o = OUT_RESET;
        case (s)
            S_RELEASE: o.ce = 1'b1;
            S_RUN: begin
                o.rst = 1'b0;
                o.ce  = 1'b1;
            end
            S_PAUSE:   o.rst = 1'b0;
            default:   o = OUT_RESET;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rst_ce_sequencer_if.sv
// Request/status bundle between a controlling agent and the reset/clock-enable sequencer.
// Level and pulse signals only; no handshake backpressure.
interface rst_ce_sequencer_if;
    logic       en_req;
    logic       pause_req;
    logic       soft_rst_req;
    logic       rst_o;
    logic       ce_o;
    logic       en_ack;
    logic       timeout_o;
    logic [2:0] state_o;

    modport master (
        output en_req, pause_req, soft_rst_req,
        input  rst_o, ce_o, en_ack, timeout_o, state_o
    );

    modport slave (
        input  en_req, pause_req, soft_rst_req,
        output rst_o, ce_o, en_ack, timeout_o, state_o
    );
endinterface

// File: rtl/cyc_down_counter.sv
// Loadable down-counter that saturates at zero; zero flag is combinational from the count.
// Load takes effect on the next edge and wins over decrement; never stalls.
module cyc_down_counter #(
    parameter int W       = 4,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= W'(RST_VAL);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/rst_ce_sequencer.sv
// Sequences downstream reset release and clock-enable so rst_o is only dropped while ce_o overlaps it.
// Outputs registered from next state (one-edge latency); requests are levels/pulses with no backpressure.
module rst_ce_sequencer
    import rst_ce_pkg::*;
#(
    parameter int HOLD_CYC    = 3,
    parameter int OVERLAP_CYC = 1,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    rst_ce_sequencer_if.slave bus
);
    localparam int CNT_W = cnt_width(HOLD_CYC, OVERLAP_CYC, TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] OVL_LD  = CNT_W'(OVERLAP_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LD  = CNT_W'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    out_t             out_q, out_d;
    logic             tmo_q, tmo_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_en;
    logic             cnt_zero;

    // One counter serves hold, overlap and timeout: every phase change reloads it.
    cyc_down_counter #(
        .W       (CNT_W),
        .RST_VAL (HOLD_CYC - 1)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_en   = 1'b0;

        case (state_q)
            S_HOLD: begin
                if (cnt_zero) begin
                    state_d  = S_ARMED;
                    cnt_load = 1'b1;
                    cnt_val  = TMO_LD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_ARMED: begin
                if (bus.en_req) begin
                    state_d  = S_RELEASE;
                    cnt_load = 1'b1;
                    cnt_val  = OVL_LD;
                end else if (cnt_zero) begin
                    tmo_d = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_RELEASE: begin
                if (cnt_zero) begin
                    state_d = S_RUN;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.pause_req) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (!bus.pause_req) state_d = S_RUN;
            end
            default: begin
                state_d  = S_HOLD;
                cnt_load = 1'b1;
                cnt_val  = HOLD_LD;
                tmo_d    = 1'b0;
            end
        endcase

        // Soft reset outranks every request except the hard reset handled in the register.
        if (bus.soft_rst_req && (state_q != S_HOLD)) begin
            state_d  = S_HOLD;
            cnt_load = 1'b1;
            cnt_val  = HOLD_LD;
            cnt_en   = 1'b0;
            tmo_d    = 1'b0;
        end

        out_d     = decode(state_d);
        out_d.ack = (state_q == S_RELEASE) && (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_HOLD;
            out_q   <= OUT_RESET;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.rst_o     = out_q.rst;
    assign bus.ce_o      = out_q.ce;
    assign bus.en_ack    = out_q.ack;
    assign bus.timeout_o = tmo_q;
    assign bus.state_o   = state_q;
endmodule

// File: tb/tb_rst_ce_sequencer.sv
// Bench: vector table, hand-written corner sequences and random stimulus against a phase/age model.
module tb_rst_ce_sequencer;
    localparam int HOLD  = 3;
    localparam int OVL   = 1;
    localparam int TMO   = 16;
    localparam int OVL_B = 3;

    localparam int P_HOLD = 0, P_ARMED = 1, P_RELEASE = 2, P_RUN = 3, P_PAUSE = 4;

    logic clk = 1'b0;
    logic rst;
    logic en_r, pause_r, soft_r;
    always #5 clk = ~clk;

    rst_ce_sequencer_if ifa();
    rst_ce_sequencer_if ifb();

    assign ifa.en_req       = en_r;
    assign ifa.pause_req    = pause_r;
    assign ifa.soft_rst_req = soft_r;
    assign ifb.en_req       = en_r;
    assign ifb.pause_req    = pause_r;
    assign ifb.soft_rst_req = soft_r;

    rst_ce_sequencer #(.HOLD_CYC(HOLD), .OVERLAP_CYC(OVL), .TIMEOUT_CYC(TMO)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave));
    rst_ce_sequencer #(.HOLD_CYC(HOLD), .OVERLAP_CYC(OVL_B), .TIMEOUT_CYC(TMO)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave));

    int n_cmp = 0;
    int n_err = 0;
    int rel_seen = 0;
    bit mon_en = 1'b0;

    task automatic chk(string name, logic [6:0] act, logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Observed bundle: {rst_o, ce_o, en_ack, timeout_o, state_o}
    function automatic logic [6:0] obs_a();
        return {ifa.rst_o, ifa.ce_o, ifa.en_ack, ifa.timeout_o, ifa.state_o};
    endfunction
    function automatic logic [6:0] obs_b();
        return {ifb.rst_o, ifb.ce_o, ifb.en_ack, ifb.timeout_o, ifb.state_o};
    endfunction

    // Reference model: phase plus cycles spent in that phase, timings compared against parameters.
    int ovl_p[2] = '{OVL, OVL_B};
    int m_ph[2]  = '{0, 0};
    int m_age[2] = '{0, 0};
    bit m_tmo[2] = '{1'b0, 1'b0};
    bit m_ack[2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int nxt;
            bit tmo;
            if (rst === 1'b1) begin
                m_ph[k] = P_HOLD; m_age[k] = 0; m_tmo[k] = 1'b0; m_ack[k] = 1'b0;
            end else begin
                nxt = m_ph[k];
                tmo = m_tmo[k];
                if (soft_r && m_ph[k] != P_HOLD) begin
                    nxt = P_HOLD;
                    tmo = 1'b0;
                end else begin
                    case (m_ph[k])
                        P_HOLD:    if (m_age[k] + 1 >= HOLD) nxt = P_ARMED;
                        P_ARMED:   if (en_r) nxt = P_RELEASE;
                                   else if (m_age[k] + 1 >= TMO) tmo = 1'b1;
                        P_RELEASE: if (m_age[k] + 1 >= ovl_p[k]) nxt = P_RUN;
                        P_RUN:     if (pause_r) nxt = P_PAUSE;
                        default:   if (!pause_r) nxt = P_RUN;
                    endcase
                end
                m_ack[k] = (m_ph[k] == P_RELEASE) && (nxt == P_RUN);
                m_age[k] = (nxt == m_ph[k]) ? m_age[k] + 1 : 0;
                m_ph[k]  = nxt;
                m_tmo[k] = tmo;
            end
        end
    end

    function automatic logic [6:0] m_out(int k);
        logic r, c;
        r = (m_ph[k] == P_HOLD) || (m_ph[k] == P_ARMED) || (m_ph[k] == P_RELEASE);
        c = (m_ph[k] == P_RELEASE) || (m_ph[k] == P_RUN);
        return {r, c, m_ack[k], m_tmo[k], 3'(m_ph[k])};
    endfunction

    task automatic step(bit r, bit e, bit p, bit s);
        rst = r; en_r = e; pause_r = p; soft_r = s;
        @(posedge clk);
        @(negedge clk);
        chk("model_a", obs_a(), m_out(0));
        chk("model_b", obs_b(), m_out(1));
    endtask

    // Release-ordering invariants on both instances every cycle.
    logic pr_r[2], pr_c[2];
    logic [2:0] pr_s[2];
    always @(negedge clk) begin
        logic r, c;
        logic [2:0] s;
        for (int k = 0; k < 2; k++) begin
            r = (k == 0) ? ifa.rst_o : ifb.rst_o;
            c = (k == 0) ? ifa.ce_o : ifb.ce_o;
            s = (k == 0) ? ifa.state_o : ifb.state_o;
            if (mon_en) begin
                chk("inv_rst_fall", {6'd0, !(pr_r[k] === 1'b1 && r === 1'b0) ||
                                           (pr_c[k] === 1'b1 && c === 1'b1)}, 7'd1);
                chk("inv_no_gap", {6'd0, (s > 3'd2) || (r === 1'b1) || (c === 1'b1)}, 7'd1);
                chk("inv_ce_from_hold", {6'd0, !(pr_s[k] === 3'd0 && pr_c[k] === 1'b0 && c === 1'b1)}, 7'd1);
                if (k == 0 && pr_r[k] === 1'b1 && r === 1'b0) rel_seen++;
            end
            pr_r[k] = r; pr_c[k] = c; pr_s[k] = s;
        end
    end

    typedef struct {
        bit r, e, p, s;
        logic [6:0] exp;
        string nm;
    } vec_t;
    vec_t vecs[16];

    function automatic vec_t mk(bit r, bit e, bit p, bit s, logic [6:0] exp, string nm);
        vec_t v;
        v.r = r; v.e = e; v.p = p; v.s = s; v.exp = exp; v.nm = nm;
        return v;
    endfunction

    initial begin
        rst = 1'b1; en_r = 1'b0; pause_r = 1'b0; soft_r = 1'b0;

        vecs[0]  = mk(1, 0, 0, 0, 7'b1000000, "reset0");
        vecs[1]  = mk(1, 0, 0, 0, 7'b1000000, "reset1");
        vecs[2]  = mk(1, 0, 0, 0, 7'b1000000, "reset2");
        vecs[3]  = mk(0, 1, 0, 0, 7'b1000000, "hold_ign_en1");
        vecs[4]  = mk(0, 1, 0, 0, 7'b1000000, "hold_ign_en2");
        vecs[5]  = mk(0, 1, 0, 0, 7'b1000001, "armed_3rd_edge");
        vecs[6]  = mk(0, 1, 0, 0, 7'b1100010, "release");
        vecs[7]  = mk(0, 0, 0, 0, 7'b0110011, "run_ack");
        vecs[8]  = mk(0, 0, 0, 0, 7'b0100011, "run_no_ack");
        vecs[9]  = mk(0, 0, 1, 0, 7'b0000100, "pause1");
        vecs[10] = mk(0, 0, 1, 0, 7'b0000100, "pause2");
        vecs[11] = mk(0, 0, 1, 0, 7'b0000100, "pause3");
        vecs[12] = mk(0, 0, 1, 0, 7'b0000100, "pause4");
        vecs[13] = mk(0, 0, 0, 0, 7'b0100011, "resume_no_ack");
        vecs[14] = mk(0, 0, 0, 0, 7'b0100011, "run_steady");
        vecs[15] = mk(0, 0, 1, 1, 7'b1000000, "soft_and_pause");

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].r, vecs[i].e, vecs[i].p, vecs[i].s);
            chk({"tbl_", vecs[i].nm}, obs_a(), vecs[i].exp);
            if (i == 0) mon_en = 1'b1;
        end

        // Timeout: 16 idle ARMED cycles, sticky, en_req still honoured, soft reset clears.
        step(0, 0, 0, 0); chk("tmo_hold1", obs_a(), 7'b1000000);
        step(0, 0, 0, 0); chk("tmo_hold2", obs_a(), 7'b1000000);
        step(0, 0, 0, 0); chk("tmo_armed", obs_a(), 7'b1000001);
        for (int i = 1; i < TMO; i++) begin
            step(0, 0, 0, 0);
            chk("tmo_before", obs_a(), 7'b1000001);
        end
        step(0, 0, 0, 0); chk("tmo_set", obs_a(), 7'b1001001);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("tmo_sticky", obs_a(), 7'b1001001);
        end
        step(0, 1, 0, 0); chk("tmo_release", obs_a(), 7'b1101010);
        step(0, 0, 0, 0); chk("tmo_run_ack", obs_a(), 7'b0111011);
        step(0, 0, 0, 1); chk("tmo_soft_clr", obs_a(), 7'b1000000);

        // Hard reset and en_req together in ARMED.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0); chk("armed_again", obs_a(), 7'b1000001);
        step(1, 1, 0, 0); chk("rst_en_armed", obs_a(), 7'b1000000);

        // Reset in the 2nd RELEASE cycle of the 3-cycle-overlap instance.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0); chk("b_armed", obs_b(), 7'b1000001);
        step(0, 1, 0, 0); chk("b_release1", obs_b(), 7'b1100010);
        step(0, 0, 0, 0); chk("b_release2", obs_b(), 7'b1100010);
        step(1, 0, 0, 0); chk("b_mid_release_rst", obs_b(), 7'b1000000);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(63) == 0, $urandom_range(3) == 0,
                 $urandom_range(2) == 0, $urandom_range(31) == 0);
        end

        chk("until_nonvacuous", {6'd0, rel_seen > 0}, 7'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
